// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load formatting and one-entry merge buffer for long-latency results.
module wb_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_addr_lo,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [4:0]       mem_rd,
    input  logic             stall,
    input  logic             flush,
    input  logic             lu_valid,
    input  logic [4:0]       lu_rd,
    input  logic [WIDTH-1:0] lu_data,
    output logic             lu_ready,
    output logic             regwrite,
    output logic [4:0]       address_wb,
    output logic [WIDTH-1:0] data_wb,
    output logic             lu_pending,
    output logic [4:0]       lu_pending_rd
);
    logic             live, accept, buf_valid;
    logic [4:0]       buf_rd;
    logic [WIDTH-1:0] buf_data, fmt;
    logic [7:0]       b;
    logic [15:0]      h;

    always_comb begin
        b = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
        h = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        fmt = !mem_memtoreg           ? mem_alu_result :
              mem_load_type == 3'b001 ? {{(WIDTH-8){b[7]}}, b} :
              mem_load_type == 3'b010 ? {{(WIDTH-8){1'b0}}, b} :
              mem_load_type == 3'b011 ? {{(WIDTH-16){h[15]}}, h} :
              mem_load_type == 3'b100 ? {{(WIDTH-16){1'b0}}, h} :
                                        mem_rdata;
    end

    assign live          = mem_valid & mem_regwrite & ~stall & ~flush & (mem_rd != 5'd0);
    assign accept        = lu_valid & ~buf_valid;
    assign lu_ready      = ~buf_valid;
    assign lu_pending    = buf_valid;
    assign lu_pending_rd = buf_rd;

    // Priority: pipeline, then buffered result, then bypass of a fresh long-latency result.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite   <= 1'b0;
            address_wb <= '0;
            data_wb    <= '0;
            buf_valid  <= 1'b0;
            buf_rd     <= '0;
            buf_data   <= '0;
        end else begin
            regwrite <= 1'b0;
            if (live) begin
                regwrite   <= 1'b1;
                address_wb <= mem_rd;
                data_wb    <= fmt;
            end else if (buf_valid) begin
                regwrite   <= 1'b1;
                address_wb <= buf_rd;
                data_wb    <= buf_data;
                buf_valid  <= 1'b0;
            end else if (accept && lu_rd != 5'd0) begin
                regwrite   <= 1'b1;
                address_wb <= lu_rd;
                data_wb    <= lu_data;
            end
            if (accept && live && lu_rd != 5'd0) begin
                buf_valid <= 1'b1;
                buf_rd    <= lu_rd;
                buf_data  <= lu_data;
            end
        end
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined MIPS core: the writer side of the register file write port (`regwrite`, `address_wb`, `data_wb`).
- Holds the MEM/WB pipeline register and formats load data (byte/half extraction, sign/zero extension).
- Merges completions from a long-latency unit (multiplier/divider) through a one-entry buffer. Pipeline results always take priority.
- Outputs are registered on posedge clk, so they are stable when the register file writes on negedge.

Parameters:
WIDTH, 32, datapath width; must be 32 for load formatting.

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
mem_valid  input  1  MEM stage holds a real instruction
mem_regwrite  input  1  instruction writes rd
mem_memtoreg  input  1  1 = load data, 0 = ALU result
mem_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
mem_addr_lo  input  2  low two bits of the load address
mem_alu_result  input  WIDTH  ALU result
mem_rdata  input  WIDTH  raw data-memory word
mem_rd  input  5  destination register
stall  input  1  MEM stage stalled this cycle
flush  input  1  kill the MEM-stage instruction
lu_valid  input  1  long-latency result offered
lu_rd  input  5  long-latency destination
lu_data  input  WIDTH  long-latency result
lu_ready  output  1  buffer can accept (= ~buf_valid)
regwrite  output  1  register file write enable
address_wb  output  5  register file write address
data_wb  output  WIDTH  register file write data
lu_pending  output  1  buffer holds an unwritten result
lu_pending_rd  output  5  buffer destination, for the hazard unit

Behaviour:
- Reset (posedge with rst=1) clears regwrite, address_wb, data_wb, buf_valid and the buffer rd/data to 0. After reset, lu_ready=1 and lu_pending=0.
- Pipeline slot is live when `mem_valid & mem_regwrite & ~stall & ~flush & (mem_rd != 0)`.
  - stall or flush inserts a bubble into WB. The held instruction is never written twice.
- Pipeline slot live at posedge N → regwrite=1, address_wb=mem_rd, data_wb=formatted value, visible after posedge N. Latency is exactly 1 cycle.
- Otherwise regwrite=0, and address_wb/data_wb keep their previous values.
- Formatting when mem_memtoreg=1 (little-endian):
  - LW: the whole word; mem_addr_lo is ignored.
  - LB / LBU: byte at bits [8*addr_lo+7 : 8*addr_lo], sign-extended (LB) or zero-extended (LBU).
  - LH / LHU: half selected by addr_lo[1] (0 → [15:0], 1 → [31:16]); addr_lo[0] is ignored; sign- or zero-extended.
  - Reserved load_type codes (101–111) behave as LW.
- mem_memtoreg=0 → data = mem_alu_result.
- Long-latency path, evaluated each posedge with rst=0:
  - accept = lu_valid & ~buf_valid.
  - free_slot = ~(pipeline slot live).
  - buf_valid & free_slot: write the buffer (regwrite=1, address_wb=buf_rd, data_wb=buf_data) and clear buf_valid. An incoming lu_valid is not accepted this cycle because lu_ready=0.
  - ~buf_valid & accept & free_slot: bypass. Write lu_rd/lu_data directly; buf_valid stays 0.
  - ~buf_valid & accept & ~free_slot: capture into the buffer and set buf_valid=1.
  - accept with lu_rd=0: the transaction completes, the write is dropped, buf_valid is not set.
- Starvation: the buffer waits indefinitely while the pipeline slot stays live. There is no priority inversion; the hazard unit uses lu_pending/lu_pending_rd to stall readers of that rd.
- Same-rd pipeline/long-latency ordering is guaranteed by the hazard unit and is not checked here.
- At most one register file write per cycle.
- rst asserted mid-operation discards any buffered result, with no write.

Test Plan:
- Reset → regwrite=0, address_wb=0, data_wb=0, lu_ready=1, lu_pending=0.
- ALU op: mem_valid=1, regwrite=1, memtoreg=0, rd=5, alu=0x0000_1234 → next cycle regwrite=1, address_wb=5, data_wb=0x0000_1234. Same with rd=0 → regwrite=0.
- Loads with rdata=0x80F1_7F82:
  - LB addr_lo=0 → 0xFFFF_FF82.
  - LBU addr_lo=0 → 0x0000_0082.
  - LB addr_lo=1 → 0x0000_007F.
  - LH addr_lo=2 → 0xFFFF_80F1.
  - LHU addr_lo=2 → 0x0000_80F1.
  - LW → 0x80F1_7F82.
- Stall and flush: live instruction rd=7 with stall=1 for 3 cycles → regwrite=0 for those cycles, then exactly one write of r7 after release. Flush=1 → no write.
- Conflict: lu_valid rd=9 data=0xDEAD_BEEF in the same cycle as a live pipeline write rd=3 → r3 written first, lu_pending=1, lu_pending_rd=9, lu_ready=0. Next free cycle → r9=0xDEAD_BEEF written, lu_ready=1.
- Bypass and reset: lu_valid rd=4 with no pipeline write → r4 written next cycle and lu_pending stays 0. A buffered result with rst=1 asserted before drain → no write, and lu_pending=0 after reset.
